// File: rtl/noc_pkg.sv
// Shared flit format, port enumeration and routing helpers for the 5-port mesh router.
package noc_pkg;

    localparam int FIFO_DEPTH = 2;
    localparam int NPORTS     = 5;
    localparam int FLIT_W     = 18;

    typedef struct packed {
        logic [1:0]  dx;
        logic [1:0]  dy;
        logic [12:0] payload;
        logic        valid;
    } flit_t;

    // Enum order is also the round-robin scan order.
    typedef enum logic [2:0] {
        L = 3'd0,
        N = 3'd1,
        E = 3'd2,
        S = 3'd3,
        W = 3'd4
    } port_e;

    function automatic port_e xy_route(input logic [1:0] dx, input logic [1:0] dy,
                                       input logic [1:0] x,  input logic [1:0] y);
        port_e p;
        if (dx < x)      p = W;
        else if (dx > x) p = E;
        else if (dy < y) p = S;
        else if (dy > y) p = N;
        else             p = L;
        return p;
    endfunction

    function automatic logic [2:0] rr_add(input logic [2:0] base, input logic [2:0] off);
        logic [3:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= 4'(NPORTS)) sum = sum - 4'(NPORTS);
        return sum[2:0];
    endfunction

endpackage

// File: rtl/noc_in_fifo.sv
// Per-input flit queue; writes every valid flit it has room for, head is read combinationally.
module noc_in_fifo
    import noc_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  flit_t flit_i,
    input  logic  pop_i,
    output flit_t head_o,
    output logic  vld_o
);
    localparam int            AW   = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   FULL = (AW+1)'(FIFO_DEPTH);

    flit_t         mem_q [FIFO_DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push;

    // A full queue still accepts when its head leaves on the same edge.
    assign push = flit_i.valid && ((cnt_q != FULL) || pop_i);

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        if (push)  wr_d = wr_q + 1'b1;
        if (pop_i) rd_d = rd_q + 1'b1;
        cnt_d = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop_i};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= flit_i;
    end

    assign head_o = mem_q[rd_q];
    assign vld_o  = (cnt_q != '0);

endmodule

// File: rtl/noc_router.sv
// 5-port XY mesh router: per-input FIFOs, per-output round-robin arbiters and registered outputs.
module noc_router
    import noc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [17:0] W_IN,
    input  logic [17:0] E_IN,
    input  logic [17:0] N_IN,
    input  logic [17:0] S_IN,
    input  logic [17:0] L_IN,
    input  logic [1:0]  X_IN,
    input  logic [1:0]  Y_IN,
    output logic [17:0] W_OUT,
    output logic [17:0] E_OUT,
    output logic [17:0] N_OUT,
    output logic [17:0] S_OUT,
    output logic [17:0] L_OUT
);
    flit_t [NPORTS-1:0]              in_flit, head;
    logic  [NPORTS-1:0]              hvld, pop;
    port_e                           dest [NPORTS];
    logic  [NPORTS-1:0][NPORTS-1:0]  req;          // [output][input]
    logic  [NPORTS-1:0][FLIT_W-1:0]  out_q, out_d;
    logic  [NPORTS-1:0][2:0]         ptr_q, ptr_d;
    logic  [2:0]                     idx;
    logic                            found;

    assign in_flit[L] = flit_t'(L_IN);
    assign in_flit[N] = flit_t'(N_IN);
    assign in_flit[E] = flit_t'(E_IN);
    assign in_flit[S] = flit_t'(S_IN);
    assign in_flit[W] = flit_t'(W_IN);

    for (genvar g = 0; g < NPORTS; g++) begin : g_in
        noc_in_fifo u_fifo (
            .clk    (clk),
            .rst    (rst),
            .flit_i (in_flit[g]),
            .pop_i  (pop[g]),
            .head_o (head[g]),
            .vld_o  (hvld[g])
        );
        assign dest[g] = xy_route(head[g].dx, head[g].dy, X_IN, Y_IN);
    end

    // Each head requests exactly one output, so an input is popped at most once per cycle.
    always_comb begin
        req   = '0;
        pop   = '0;
        out_d = '0;
        ptr_d = ptr_q;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NPORTS; i++)
            req[dest[i]][i] = hvld[i];
        for (int o = 0; o < NPORTS; o++) begin
            found = 1'b0;
            for (int k = 0; k < NPORTS; k++) begin
                idx = rr_add(ptr_q[o], 3'(k));
                if (!found && req[o][idx]) begin
                    found    = 1'b1;
                    out_d[o] = head[idx];
                    pop[idx] = 1'b1;
                    ptr_d[o] = rr_add(idx, 3'd1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q <= '0;
            ptr_q <= {NPORTS{3'(L)}};
        end else begin
            out_q <= out_d;
            ptr_q <= ptr_d;
        end
    end

    assign L_OUT = out_q[L];
    assign N_OUT = out_q[N];
    assign E_OUT = out_q[E];
    assign S_OUT = out_q[S];
    assign W_OUT = out_q[W];

endmodule

// File: tb/tb_noc_router.sv
// Scoreboard bench for noc_router: expected flits are queued with their due cycle and checked per output.
module tb_noc_router;
    localparam int PL = 0, PN = 1, PE = 2, PS = 3, PW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  x_in = 2'd3;
    logic [1:0]  y_in = 2'd1;
    logic [17:0] in_v [5];
    logic [17:0] outs [5];

    typedef struct {
        int          port;
        int          cyc;
        logic [17:0] val;
    } exp_t;

    exp_t sb [$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    noc_router dut (
        .clk   (clk),
        .rst   (rst),
        .W_IN  (in_v[PW]),
        .E_IN  (in_v[PE]),
        .N_IN  (in_v[PN]),
        .S_IN  (in_v[PS]),
        .L_IN  (in_v[PL]),
        .X_IN  (x_in),
        .Y_IN  (y_in),
        .W_OUT (outs[PW]),
        .E_OUT (outs[PE]),
        .N_OUT (outs[PN]),
        .S_OUT (outs[PS]),
        .L_OUT (outs[PL])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected value for output p at the current cycle; 0 when nothing is due.
    function automatic logic [17:0] sb_take(input int p);
        logic [17:0] v;
        v = '0;
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].port == p && sb[i].cyc == cyc) begin
                v = sb[i].val;
                sb.delete(i);
                break;
            end
        end
        return v;
    endfunction

    task automatic clear_inputs();
        for (int p = 0; p < 5; p++) in_v[p] = '0;
    endtask

    task automatic do_reset(input logic [1:0] x, input logic [1:0] y);
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        sb.delete();
        x_in = x;
        y_in = y;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [17:0] e;
        for (int p = 0; p < 5; p++) in_v[p] = 18'h3C001 + 18'(p * 2);
        #1;
        for (int p = 0; p < 5; p++) begin
            checks++;
            if (outs[p] !== 18'h0) begin
                failures++;
                $display("FAIL reset_async port%0d got=%h exp=%h", p, outs[p], 18'h0);
            end
        end
        repeat (2) @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            for (int p = 0; p < 5; p++) begin
                e = sb_take(p);
                checks++;
                if (outs[p] !== e) begin
                    failures++;
                    $display("FAIL reset_idle port%0d cyc%0d got=%h exp=%h", p, cyc, outs[p], e);
                end
            end
        end
    endtask

    task automatic test_route();
        logic [17:0] e;
        logic [17:0] fl [5];
        int          src [5];
        int          dst [5];
        fl  = '{18'h1a349, 18'h34001, 18'h30157, 18'h2ABCD, 18'h38003};
        src = '{PS, PN, PL, PW, PE};
        dst = '{PW, PL, PS, PW, PN};
        do_reset(2'd3, 2'd1);
        for (int t = 0; t < 9; t++) begin
            @(negedge clk);
            for (int p = 0; p < 5; p++) begin
                e = sb_take(p);
                checks++;
                if (outs[p] !== e) begin
                    failures++;
                    $display("FAIL route port%0d cyc%0d got=%h exp=%h", p, cyc, outs[p], e);
                end
            end
            clear_inputs();
            if (t < 5) begin
                in_v[src[t]] = fl[t];
                sb.push_back('{dst[t], cyc + 2, fl[t]});
            end
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL route_drain left=%0d exp=0", sb.size());
        end
    endtask

    task automatic test_parallel();
        logic [17:0] e;
        do_reset(2'd1, 2'd2);
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            for (int p = 0; p < 5; p++) begin
                e = sb_take(p);
                checks++;
                if (outs[p] !== e) begin
                    failures++;
                    $display("FAIL parallel port%0d cyc%0d got=%h exp=%h", p, cyc, outs[p], e);
                end
            end
            clear_inputs();
            if (t == 0) begin
                in_v[PE] = 18'h20005; sb.push_back('{PE, cyc + 2, 18'h20005});
                in_v[PW] = 18'h1C0FF; sb.push_back('{PN, cyc + 2, 18'h1C0FF});
                in_v[PN] = 18'h10011; sb.push_back('{PS, cyc + 2, 18'h10011});
                in_v[PS] = 18'h0F0F1; sb.push_back('{PW, cyc + 2, 18'h0F0F1});
                in_v[PL] = 18'h18003; sb.push_back('{PL, cyc + 2, 18'h18003});
            end
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL parallel_drain left=%0d exp=0", sb.size());
        end
    endtask

    task automatic test_contend();
        logic [17:0] e;
        do_reset(2'd3, 2'd1);
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            for (int p = 0; p < 5; p++) begin
                e = sb_take(p);
                checks++;
                if (outs[p] !== e) begin
                    failures++;
                    $display("FAIL contend port%0d cyc%0d got=%h exp=%h", p, cyc, outs[p], e);
                end
            end
            clear_inputs();
            if (t == 0) begin
                in_v[PW] = 18'h3C001;
                in_v[PE] = 18'h3C003;
                sb.push_back('{PN, cyc + 2, 18'h3C003});
                sb.push_back('{PN, cyc + 3, 18'h3C001});
            end
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL contend_drain left=%0d exp=0", sb.size());
        end
    endtask

    task automatic test_invalid();
        logic [17:0] e;
        do_reset(2'd3, 2'd1);
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            for (int p = 0; p < 5; p++) begin
                e = sb_take(p);
                checks++;
                if (outs[p] !== e) begin
                    failures++;
                    $display("FAIL invalid port%0d cyc%0d got=%h exp=%h", p, cyc, outs[p], e);
                end
            end
            clear_inputs();
            if (t < 2) in_v[PE] = 18'h1a348;
        end
    endtask

    task automatic test_full_drop();
        logic [17:0] e;
        logic [17:0] ef [4];
        logic [17:0] wf [4];
        int          base;
        ef = '{18'h3C011, 18'h3C013, 18'h3C015, 18'h3C017};
        wf = '{18'h3C021, 18'h3C023, 18'h3C025, 18'h3C027};
        do_reset(2'd3, 2'd1);
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            for (int p = 0; p < 5; p++) begin
                e = sb_take(p);
                checks++;
                if (outs[p] !== e) begin
                    failures++;
                    $display("FAIL full_drop port%0d cyc%0d got=%h exp=%h", p, cyc, outs[p], e);
                end
            end
            clear_inputs();
            if (t == 0) begin
                base = cyc;
                // E and W alternate on N; the fourth W flit finds its queue full and is lost.
                sb.push_back('{PN, base + 2, ef[0]});
                sb.push_back('{PN, base + 3, wf[0]});
                sb.push_back('{PN, base + 4, ef[1]});
                sb.push_back('{PN, base + 5, wf[1]});
                sb.push_back('{PN, base + 6, ef[2]});
                sb.push_back('{PN, base + 7, wf[2]});
                sb.push_back('{PN, base + 8, ef[3]});
            end
            if (t < 4) begin
                in_v[PE] = ef[t];
                in_v[PW] = wf[t];
            end
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL full_drop_drain left=%0d exp=0", sb.size());
        end
    endtask

    task automatic test_reset_midflight();
        logic [17:0] e;
        do_reset(2'd3, 2'd1);
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            for (int p = 0; p < 5; p++) begin
                e = sb_take(p);
                checks++;
                if (outs[p] !== e) begin
                    failures++;
                    $display("FAIL midflight_pre port%0d cyc%0d got=%h exp=%h", p, cyc, outs[p], e);
                end
            end
            clear_inputs();
            if (t == 0) begin
                sb.push_back('{PN, cyc + 2, 18'h3C011});
                sb.push_back('{PN, cyc + 3, 18'h3C021});
            end
            in_v[PE] = 18'h3C011 + 18'(t * 2);
            in_v[PW] = 18'h3C021 + 18'(t * 2);
        end
        #2;
        rst = 1'b0;
        #1;
        for (int p = 0; p < 5; p++) begin
            checks++;
            if (outs[p] !== 18'h0) begin
                failures++;
                $display("FAIL midflight_async port%0d got=%h exp=%h", p, outs[p], 18'h0);
            end
        end
        sb.delete();
        repeat (2) @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            for (int p = 0; p < 5; p++) begin
                e = sb_take(p);
                checks++;
                if (outs[p] !== e) begin
                    failures++;
                    $display("FAIL midflight_stale port%0d cyc%0d got=%h exp=%h", p, cyc, outs[p], e);
                end
            end
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_route();
        test_parallel();
        test_contend();
        test_invalid();
        test_full_drop();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
